// File: rtl/sram_seg_bridge.sv
// Bridges 16-bit segmented SRAM requests onto two 2048x128 single-port macros (imem/dmem).
// Reads extract one slice; writes read-modify-write the whole word so neighbouring slices survive.
module sram_seg_bridge #(
    parameter int ADDR_W = 11,
    parameter int SEG_W  = 16,
    parameter int NSEG   = 8,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sram_ren,
    input  logic                     sram_wen,
    input  logic [ADDR_W-1:0]        sram_addr,
    input  logic [$clog2(NSEG)-1:0]  sram_seg_sel,
    input  logic [SEG_W-1:0]         sram_wdata,
    output logic [SEG_W-1:0]         sram_rdata,
    output logic                     sram_ready,
    input  logic                     id_sel,
    output logic                     imem_ce,
    output logic                     dmem_ce,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [SEG_W*NSEG-1:0]    mem_wdata,
    input  logic [SEG_W*NSEG-1:0]    imem_rdata,
    input  logic [SEG_W*NSEG-1:0]    dmem_rdata,
    output logic                     busy,
    output logic                     err_both
);
    localparam int SEL_W  = $clog2(NSEG);
    localparam int WORD_W = SEG_W * NSEG;

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE} state_t;

    state_t              state, state_nxt;
    logic [1:0]          cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [SEL_W-1:0]    seg_q;
    logic [SEG_W-1:0]    wdata_q;
    logic                id_q;
    logic                op_wr;
    logic [WORD_W-1:0]   word_q;
    logic [SEG_W-1:0]    rdata_q;
    logic                err_q;
    logic [WORD_W-1:0]   rd_word;
    logic [WORD_W-1:0]   merged;
    logic                req;
    logic                wait_last;

    assign req       = sram_ren | sram_wen;
    assign wait_last = (cnt == 2'd1);
    assign rd_word   = id_q ? imem_rdata : dmem_rdata;

    // Write word: latched slice replaces segment seg_q, all others pass through untouched.
    always_comb begin
        merged = word_q;
        for (int k = 0; k < NSEG; k++) begin
            if (seg_q == SEL_W'(k)) merged[k*SEG_W +: SEG_W] = wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            seg_q   <= '0;
            wdata_q <= '0;
            id_q    <= 1'b0;
            op_wr   <= 1'b0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (req) begin
                    addr_q  <= sram_addr;
                    seg_q   <= sram_seg_sel;
                    wdata_q <= sram_wdata;
                    id_q    <= id_sel;
                    op_wr   <= sram_wen;
                    if (sram_ren && sram_wen) err_q <= 1'b1;
                end
                RD:   cnt <= 2'(RD_LAT);
                WAIT: begin
                    cnt <= cnt - 2'd1;
                    if (wait_last) begin
                        word_q <= rd_word;
                        if (!op_wr) rdata_q <= rd_word[seg_q*SEG_W +: SEG_W];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        imem_ce    = 1'b0;
        dmem_ce    = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        sram_ready = 1'b0;
        case (state)
            IDLE: if (req) state_nxt = RD;
            RD: begin
                imem_ce   = id_q;
                dmem_ce   = ~id_q;
                state_nxt = WAIT;
            end
            WAIT: if (wait_last) state_nxt = op_wr ? WR : DONE;
            WR: begin
                imem_ce   = id_q;
                dmem_ce   = ~id_q;
                mem_we    = 1'b1;
                mem_wdata = merged;
                state_nxt = DONE;
            end
            DONE: begin
                sram_ready = 1'b1;
                if (!sram_ren && !sram_wen) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_addr   = addr_q;
    assign sram_rdata = rdata_q;
    assign busy       = (state != IDLE);
    assign err_both   = err_q;

endmodule
